mem_block_master: RTL and testbench

- Avalon-MM initiator that runs word-granular block operations against the 32-bit single-port on-chip memory slave: fill, copy and verify.
- Sits between a control source (Nios custom logic or a test sequencer) and the memory's s2 slave port.
- Produces the address, byteenable, chipselect, write and writedata signals the memory consumes, and samples its readdata at a fixed read latency.

---
 rtl/mem_block_master.sv | 205 ++++++++++++++++++++
 tb/tb_mem_block_master.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_master.sv
// mem_block_master: word-granular fill / copy / verify initiator driving the
// s2 port of a 32-bit single-port on-chip memory with a fixed read latency.
// Bus outputs are decoded from registered state, so they fall as soon as
// reset_n is asserted.
module mem_block_master #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1   // legal range 1..4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [31:0]       pattern,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic              m_clken,
  input  logic [31:0]       m_readdata
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_WR       = 3'd3;
  localparam logic [2:0] S_FINISH   = 3'd4;

  localparam logic [1:0] M_FILL   = 2'd0;
  localparam logic [1:0] M_COPY   = 2'd1;
  localparam logic [1:0] M_VERIFY = 2'd2;
  localparam logic [1:0] M_BAD    = 2'd3;

  // Wait counter runs 0..READ_LATENCY-1; 3 bits covers the 1..4 range.
  localparam logic [2:0]      WAIT_LAST = 3'(READ_LATENCY - 1);
  localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [31:0]       pat_q, pat_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] eaddr_q, eaddr_d;

  // Per-word derived values; address sums wrap modulo 2^ADDR_W.
  logic [ADDR_W-1:0] src_word;
  logic [ADDR_W-1:0] dst_word;
  logic [31:0]       pat_word;
  logic              last_word;

  assign src_word  = src_q + idx_q[ADDR_W-1:0];
  assign dst_word  = dst_q + idx_q[ADDR_W-1:0];
  assign pat_word  = pat_q + 32'(idx_q);
  assign last_word = (idx_q + IDX_ONE) == len_q;

  // Next-state logic: command capture, word sequencing and verify compare.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    eaddr_d = eaddr_q;

    case (state_q)
      // FINISH already shows busy=0, so a start there is honoured as well.
      S_IDLE, S_FINISH: begin
        if (start) begin
          mode_d = mode;
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = len;
          pat_d  = pattern;
          idx_d  = '0;
          wcnt_d = '0;
          err_d  = 1'b0;
          if (mode == M_BAD) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else if (len == '0) begin
            state_d = S_FINISH;
          end else if (mode == M_FILL) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RD_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_RD_WAIT;
      end

      // Read data is taken on the edge closing the last wait cycle.
      S_RD_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          if (mode_q == M_COPY) begin
            rdata_d = m_readdata;
            state_d = S_WR;
          end else begin
            // Only the first mismatch of an operation records its address.
            if ((m_readdata != pat_word) && !err_q) begin
              err_d   = 1'b1;
              eaddr_d = dst_word;
            end
            idx_d   = idx_q + IDX_ONE;
            state_d = last_word ? S_FINISH : S_RD_ISSUE;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end

      S_WR: begin
        idx_d = idx_q + IDX_ONE;
        if (last_word)
          state_d = S_FINISH;
        else if (mode_q == M_FILL)
          state_d = S_WR;
        else
          state_d = S_RD_ISSUE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and command registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_FILL;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      eaddr_q <= eaddr_d;
    end
  end

  // Bus and status decode from the registered state.
  always_comb begin
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    m_address    = '0;
    m_writedata  = '0;
    case (state_q)
      S_RD_ISSUE: begin
        m_chipselect = 1'b1;
        m_address    = (mode_q == M_COPY) ? src_word : dst_word;
      end
      S_WR: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = dst_word;
        m_writedata  = (mode_q == M_FILL) ? pat_word : rdata_q;
      end
      default: ;
    endcase
  end

  assign m_byteenable = m_chipselect ? 4'hF : 4'h0;
  assign m_clken      = 1'b1;
  assign busy         = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done         = (state_q == S_FINISH);
  assign error        = err_q;
  assign err_addr     = eaddr_q;

endmodule

// File: tb/tb_mem_block_master.sv
// Bench for mem_block_master: a behavioural memory slave plus a per-cycle
// expectation queue built from the operation rules, with literal checks of
// memory contents, latencies and error reporting.
module tb_mem_block_master;

  localparam int AW = 10;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   len;
  logic [31:0]   pattern;
  logic          busy, done, error;
  logic [AW-1:0] err_addr, m_address;
  logic [3:0]    m_byteenable;
  logic          m_chipselect, m_write, m_clken;
  logic [31:0]   m_writedata, m_readdata;

  always #5 clk = ~clk;

  mem_block_master #(.ADDR_W(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_write(m_write),
    .m_writedata(m_writedata), .m_clken(m_clken), .m_readdata(m_readdata)
  );

  // Memory slave with one cycle of read latency, plus bench-side clear/poke.
  logic [31:0]   mem [0:1023];
  logic          clr_mem = 1'b0, poke_en = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [31:0]   poke_d = '0;

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 32'h0;
    end else if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (m_chipselect && m_write) begin
      mem[m_address] <= m_writedata;
    end
    if (m_chipselect && !m_write) m_readdata <= mem[m_address];
  end

  // Expected per-cycle bus/status picture.
  typedef struct {
    logic          cs, we, bsy, dn, er;
    logic [AW-1:0] addr, eaddr;
    logic [31:0]   wdata;
  } exp_t;

  exp_t          q[$];
  logic [31:0]   mref [0:1023];
  logic          m_err = 1'b0;         // model error at end of queued op
  logic [AW-1:0] m_eaddr = '0;         // model err_addr (persists across ops)
  logic          exp_err = 1'b0;       // status expected while idle
  logic [AW-1:0] exp_eaddr = '0;
  int            nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic push(input logic cs, we, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic bsy, dn, er, input logic [AW-1:0] ea);
    exp_t e;
    e.cs = cs; e.we = we; e.addr = a; e.wdata = d;
    e.bsy = bsy; e.dn = dn; e.er = er; e.eaddr = ea;
    q.push_back(e);
  endtask

  // Expected cycles of one operation, from its word-level definition.
  task automatic build(input logic [1:0] md, input logic [AW-1:0] s, d,
                       input logic [AW:0] n, input logic [31:0] p);
    logic [31:0]   tmp [0:1023];
    logic [AW-1:0] as, ad;
    logic [31:0]   pw;
    tmp   = mref;
    m_err = (md == 2'd3);
    if (md != 2'd3) begin
      for (int k = 0; k < int'(n); k++) begin
        as = s + AW'(k);
        ad = d + AW'(k);
        pw = p + 32'(k);
        case (md)
          2'd0: begin
            push(1, 1, ad, pw, 1, 0, 0, 0);
            tmp[ad] = pw;
          end
          2'd1: begin
            push(1, 0, as, 0, 1, 0, 0, 0);
            for (int w = 0; w < RL; w++) push(0, 0, 0, 0, 1, 0, 0, 0);
            push(1, 1, ad, tmp[as], 1, 0, 0, 0);
            tmp[ad] = tmp[as];
          end
          default: begin
            push(1, 0, ad, 0, 1, 0, 0, 0);
            for (int w = 0; w < RL; w++) push(0, 0, 0, 0, 1, 0, 0, 0);
            if (tmp[ad] != pw && !m_err) begin
              m_err   = 1'b1;
              m_eaddr = ad;
            end
          end
        endcase
      end
    end
    push(0, 0, 0, 0, 0, 1, m_err, m_eaddr);
  endtask

  // One clock: sample at the falling edge and compare with the model.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("chipselect", 32'(m_chipselect), 32'(e.cs));
      chk("write", 32'(m_write), 32'(e.we));
      chk("byteenable", 32'(m_byteenable), e.cs ? 32'hF : 32'h0);
      if (e.cs) chk("address", 32'(m_address), 32'(e.addr));
      if (e.we) begin
        chk("writedata", m_writedata, e.wdata);
        mref[e.addr] = e.wdata;
      end
      chk("busy", 32'(busy), 32'(e.bsy));
      chk("done", 32'(done), 32'(e.dn));
      if (e.dn) begin
        chk("error", 32'(error), 32'(e.er));
        chk("err_addr", 32'(err_addr), 32'(e.eaddr));
        exp_err   = e.er;
        exp_eaddr = e.eaddr;
      end
    end else begin
      chk("idle_chipselect", 32'(m_chipselect), 0);
      chk("idle_write", 32'(m_write), 0);
      chk("idle_byteenable", 32'(m_byteenable), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_error", 32'(error), 32'(exp_err));
      chk("idle_err_addr", 32'(err_addr), 32'(exp_eaddr));
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    mref[a] = d;
    tick();
    poke_en = 1'b0;
  endtask

  // Issue one command, optionally with a stray start while busy, and run
  // it to its done pulse. dcyc counts cycles from the accepting edge.
  task automatic run_op(input logic [1:0] md, input logic [AW-1:0] s, d,
                        input logic [AW:0] n, input logic [31:0] p, input bit glitch,
                        output int bcyc, output int dcyc);
    int cyc;
    bcyc = 0; dcyc = 0;
    mode = md; src_addr = s; dst_addr = d; len = n; pattern = p; start = 1'b1;
    build(md, s, d, n, p);
    tick();
    start = 1'b0;
    // Scramble inputs: the running operation must use its latched copy.
    mode = 2'd3; src_addr = ~s; dst_addr = ~d; len = '0; pattern = ~p;
    cyc = 1;
    while (1) begin
      if (busy) bcyc++;
      if (done) begin dcyc = cyc; break; end
      if (cyc >= 5000) begin
        nvec++; nerr++;
        $display("FAIL timeout: no done after %0d cycles, expected done", cyc);
        q.delete();
        break;
      end
      if (glitch && cyc == 3) begin
        start = 1'b1; mode = 2'd1; src_addr = 10'h010; dst_addr = 10'h050;
        len = 11'd2; pattern = 32'h0;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    tick();
  endtask

  int bc, dc;

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = '0; src_addr = '0; dst_addr = '0;
    len = '0; pattern = '0;
    for (int k = 0; k < 1024; k++) mref[k] = 32'h0;
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_err_addr", 32'(err_addr), 0);
    chk("rst_chipselect", 32'(m_chipselect), 0);
    chk("rst_write", 32'(m_write), 0);
    chk("rst_address", 32'(m_address), 0);
    chk("rst_writedata", m_writedata, 0);
    chk("rst_byteenable", 32'(m_byteenable), 0);
    chk("rst_clken", 32'(m_clken), 1);
    clr_mem = 1'b1;
    tick();
    clr_mem = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Fill across the top of memory, wrapping to 0.
    run_op(2'd0, 10'h000, 10'h3FE, 11'd4, 32'hA5A5_0000, 0, bc, dc);
    chk("fill_done_cycle", 32'(dc), 5);
    chk("fill_busy_cycles", 32'(bc), 4);
    chk("fill_mem3FE", mem[10'h3FE], 32'hA5A5_0000);
    chk("fill_mem3FF", mem[10'h3FF], 32'hA5A5_0001);
    chk("fill_mem000", mem[10'h000], 32'hA5A5_0002);
    chk("fill_mem001", mem[10'h001], 32'hA5A5_0003);

    // Copy three words.
    poke(10'h010, 32'h11); poke(10'h011, 32'h22); poke(10'h012, 32'h33);
    run_op(2'd1, 10'h010, 10'h200, 11'd3, 32'h0, 0, bc, dc);
    chk("copy_busy_cycles", 32'(bc), 9);
    chk("copy_mem200", mem[10'h200], 32'h11);
    chk("copy_mem201", mem[10'h201], 32'h22);
    chk("copy_mem202", mem[10'h202], 32'h33);

    // Verify passing.
    run_op(2'd2, 10'h000, 10'h3FE, 11'd4, 32'hA5A5_0000, 0, bc, dc);
    chk("verify_busy_cycles", 32'(bc), 8);
    chk("verify_pass_error", 32'(error), 0);

    // Two corrupted words: only the first is reported.
    poke(10'h3FF, 32'h0); poke(10'h000, 32'h0);
    run_op(2'd2, 10'h000, 10'h3FE, 11'd4, 32'hA5A5_0000, 0, bc, dc);
    chk("verify_fail_error", 32'(error), 1);
    chk("verify_fail_err_addr", 32'(err_addr), 32'h3FF);

    // len=0 clears error, issues nothing, done next cycle.
    run_op(2'd0, 10'h000, 10'h040, 11'd0, 32'h1, 0, bc, dc);
    chk("len0_done_cycle", 32'(dc), 1);
    chk("len0_error_cleared", 32'(error), 0);
    chk("len0_err_addr_kept", 32'(err_addr), 32'h3FF);

    // Reserved mode.
    run_op(2'd3, 10'h000, 10'h040, 11'd5, 32'h1, 0, bc, dc);
    chk("mode3_done_cycle", 32'(dc), 1);
    chk("mode3_error", 32'(error), 1);

    // Stray start while busy is ignored.
    run_op(2'd0, 10'h000, 10'h100, 11'd8, 32'h0000_1000, 1, bc, dc);
    chk("glitch_done_cycle", 32'(dc), 9);
    chk("glitch_mem107", mem[10'h107], 32'h0000_1007);
    chk("glitch_mem050", mem[10'h050], 32'h0);
    chk("glitch_error_cleared", 32'(error), 0);

    // Reset during the third word of a copy.
    mode = 2'd1; src_addr = 10'h010; dst_addr = 10'h300; len = 11'd3;
    pattern = 32'h0; start = 1'b1;
    build(2'd1, 10'h010, 10'h300, 11'd3, 32'h0);
    tick();
    start = 1'b0;
    bc = 0;
    while (!(m_chipselect && !m_write && m_address == 10'h012) && bc < 50) begin
      tick();
      bc++;
    end
    if (bc >= 50) begin
      nvec++; nerr++;
      $display("FAIL rstcopy_wait: third read not seen, expected within 50 cycles");
    end
    reset_n = 1'b0;
    #1;
    chk("rstcopy_chipselect", 32'(m_chipselect), 0);
    chk("rstcopy_write", 32'(m_write), 0);
    chk("rstcopy_busy", 32'(busy), 0);
    q.delete();
    m_err = 1'b0; m_eaddr = '0; exp_err = 1'b0; exp_eaddr = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("rstcopy_mem300", mem[10'h300], 32'h11);
    chk("rstcopy_mem301", mem[10'h301], 32'h22);
    chk("rstcopy_mem302", mem[10'h302], 32'h0);

    // Normal fill after the aborted copy.
    run_op(2'd0, 10'h000, 10'h300, 11'd3, 32'h7, 0, bc, dc);
    chk("postrst_done_cycle", 32'(dc), 4);
    chk("postrst_mem302", mem[10'h302], 32'h9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule
